// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types for the DDS sweep controller: FSM states, waveform codes,
// the shadow configuration bundle and the saturating FTW step helper.
package dds_pkg;

  localparam int PHASE_W = 28;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SWEEP = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SINE     = 2'b00,
    SQUARE   = 2'b01,
    TRIANGLE = 2'b10,
    SAW      = 2'b11
  } wave_style_t;

  typedef struct packed {
    logic [PHASE_W-1:0] start_ftw;
    logic [PHASE_W-1:0] stop_ftw;
    logic [PHASE_W-1:0] step;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
    wave_style_t        wave_style;
    logic [PHASE_W-1:0] phase_offset;
  } sweep_cfg_t;

  // Moves cur one step toward stop, landing exactly on stop instead of overshooting.
  function automatic logic [PHASE_W-1:0] step_toward(
    input logic [PHASE_W-1:0] cur,
    input logic [PHASE_W-1:0] stop,
    input logic [PHASE_W-1:0] step,
    input logic               up
  );
    logic [PHASE_W-1:0] step_eff;
    logic [PHASE_W-1:0] gap;
    step_eff = (step == '0) ? PHASE_W'(1) : step;
    gap      = up ? (stop - cur) : (cur - stop);
    if (gap <= step_eff) step_toward = stop;
    else                 step_toward = up ? (cur + step_eff) : (cur - step_eff);
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_phase_accum.sv
// Phase accumulator for one DDS channel: clear wins over enable; wraps modulo 2^PHASE_W.
module phase_accum #(
  parameter int PHASE_W = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] ftw_i,
  output logic [PHASE_W-1:0] phase_o
);

  logic [PHASE_W-1:0] phase_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       phase_q <= '0;
    else if (clear_i) phase_q <= '0;
    else if (en_i)    phase_q <= phase_q + ftw_i;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear FTW sweep sequencer for one DDS channel with shadowed configuration.
// Optional DDS_SWEEP_PHASE_SYNC_EN: clear phase on each loop reload of start_ftw.
module dds_sweep_ctrl #(
  parameter int PHASE_W = 28,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_start_ftw,
  input  logic [PHASE_W-1:0] cfg_stop_ftw,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic [1:0]         cfg_wave_style,
  input  logic [PHASE_W-1:0] cfg_phase_offset,
  input  logic               start,
  input  logic               abort,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] phase_offset,
  output logic [1:0]         wave_style,
  output logic [PHASE_W-1:0] ftw,
  output logic               busy,
  output logic               sweep_done
);

  import dds_pkg::*;

  state_t             state_q;
  sweep_cfg_t         cfg_q;
  logic [PHASE_W-1:0] ftw_q;
  logic [PHASE_W-1:0] phase_offset_q;
  wave_style_t        wave_style_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic               busy_q;
  logic               ready_q;
  logic               sweep_done_q;

  logic               xfer;
  logic               start_go;
  logic               dwell_done;
  logic               at_stop;
  logic               sweep_up;
  logic               reload;
  logic [PHASE_W-1:0] stepped_ftw;
  logic               acc_clear;
  logic               acc_en;

  assign xfer        = cfg_valid && ready_q;
  assign start_go    = start && !abort && !xfer && ((state_q == ARMED) || (state_q == HOLD));
  assign dwell_done  = (dwell_cnt_q == cfg_q.dwell);
  assign at_stop     = (ftw_q == cfg_q.stop_ftw);
  assign sweep_up    = (cfg_q.stop_ftw >= cfg_q.start_ftw);
  assign reload      = at_stop && cfg_q.loop;
  assign stepped_ftw = step_toward(ftw_q, cfg_q.stop_ftw, cfg_q.step, sweep_up);

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    if (abort || xfer || start_go) begin
      acc_clear = 1'b1;
    end else begin
      unique case (state_q)
        SWEEP: begin
          acc_en = 1'b1;
`ifdef DDS_SWEEP_PHASE_SYNC_EN
          if (dwell_done && reload) acc_clear = 1'b1;
`endif
        end
        HOLD:    acc_en    = 1'b1;
        default: acc_clear = 1'b1;
      endcase
    end
  end

  phase_accum #(.PHASE_W(PHASE_W)) u_phase_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (acc_clear),
    .en_i    (acc_en),
    .ftw_i   (ftw_q),
    .phase_o (phase)
  );

  // NOTE: shadow registers are reset too; abort and reset both leave them at a known zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cfg_q          <= '0;
      ftw_q          <= '0;
      phase_offset_q <= '0;
      wave_style_q   <= SINE;
      dwell_cnt_q    <= '0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b1;
      sweep_done_q   <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      if (abort) begin
        state_q        <= IDLE;
        cfg_q          <= '0;
        ftw_q          <= '0;
        phase_offset_q <= '0;
        wave_style_q   <= SINE;
        dwell_cnt_q    <= '0;
        busy_q         <= 1'b0;
        ready_q        <= 1'b1;
      end else if (xfer) begin
        cfg_q <= '{start_ftw:    cfg_start_ftw,
                   stop_ftw:     cfg_stop_ftw,
                   step:         cfg_step,
                   dwell:        cfg_dwell,
                   loop:         cfg_loop,
                   wave_style:   wave_style_t'(cfg_wave_style),
                   phase_offset: cfg_phase_offset};
        state_q <= ARMED;
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
      end else if (start_go) begin
        state_q        <= SWEEP;
        ftw_q          <= cfg_q.start_ftw;
        dwell_cnt_q    <= '0;
        phase_offset_q <= cfg_q.phase_offset;
        wave_style_q   <= cfg_q.wave_style;
        busy_q         <= 1'b1;
        ready_q        <= 1'b0;
      end else if (state_q == SWEEP) begin
        if (!dwell_done) begin
          dwell_cnt_q <= dwell_cnt_q + 1'b1;
        end else begin
          dwell_cnt_q <= '0;
          if (at_stop) begin
            // Stop value has served its dwell: loop reloads, otherwise only start==stop lands here.
            sweep_done_q <= !cfg_q.loop || (cfg_q.start_ftw == cfg_q.stop_ftw);
            if (reload) begin
              ftw_q <= cfg_q.start_ftw;
            end else begin
              state_q <= HOLD;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end else begin
            ftw_q <= stepped_ftw;
            if (stepped_ftw == cfg_q.stop_ftw) begin
              sweep_done_q <= 1'b1;
              if (!cfg_q.loop) begin
                state_q <= HOLD;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign cfg_ready    = ready_q;
  assign busy         = busy_q;
  assign sweep_done   = sweep_done_q;
  assign ftw          = ftw_q;
  assign phase_offset = phase_offset_q;
  assign wave_style   = wave_style_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed vector table, corner sequences, and random
// traffic against a pass-list reference model (honours DDS_SWEEP_PHASE_SYNC_EN).
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [27:0] cfg_start_ftw;
  logic [27:0] cfg_stop_ftw;
  logic [27:0] cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_loop;
  logic [1:0]  cfg_wave_style;
  logic [27:0] cfg_phase_offset;
  logic        start;
  logic        abort;
  logic [27:0] phase;
  logic [27:0] phase_offset;
  logic [1:0]  wave_style;
  logic [27:0] ftw;
  logic        busy;
  logic        sweep_done;

  int n_checks = 0;
  int n_pass   = 0;

  dds_sweep_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_start_ftw    (cfg_start_ftw),
    .cfg_stop_ftw     (cfg_stop_ftw),
    .cfg_step         (cfg_step),
    .cfg_dwell        (cfg_dwell),
    .cfg_loop         (cfg_loop),
    .cfg_wave_style   (cfg_wave_style),
    .cfg_phase_offset (cfg_phase_offset),
    .start            (start),
    .abort            (abort),
    .phase            (phase),
    .phase_offset     (phase_offset),
    .wave_style       (wave_style),
    .ftw              (ftw),
    .busy             (busy),
    .sweep_done       (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic check_outs(input string tag, input logic [27:0] e_ftw, input logic [27:0] e_phase,
                            input logic [1:0] e_sty, input logic [27:0] e_off,
                            input bit e_busy, input bit e_done, input bit e_ready);
    check({tag, " ftw"},   64'(ftw),   64'(e_ftw));
    check({tag, " phase"}, 64'(phase), 64'(e_phase));
    check({tag, " ctl{style,offset,busy,done,ready}"},
          64'({wave_style, phase_offset, busy, sweep_done, cfg_ready}),
          64'({e_sty, e_off, e_busy, e_done, e_ready}));
  endtask

  task automatic set_cfg(input logic [27:0] st, input logic [27:0] sp, input logic [27:0] stp,
                         input logic [15:0] dw, input bit lp, input logic [1:0] sty,
                         input logic [27:0] off);
    cfg_start_ftw = st; cfg_stop_ftw = sp; cfg_step = stp; cfg_dwell = dw;
    cfg_loop = lp; cfg_wave_style = sty; cfg_phase_offset = off;
  endtask

  // Inputs change just after a falling edge; outputs are examined on the next falling edge.
  task automatic drive_cycle(input bit v, input bit s, input bit a);
    cfg_valid = v; start = s; abort = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ARMED, M_SWEEP, M_HOLD} mstate_e;
  typedef struct { logic [27:0] f; bit done; } slot_t;

  mstate_e     m_state;
  logic [27:0] m_ftw, m_phase, m_off;
  logic [1:0]  m_sty;
  bit          m_done;
  logic [27:0] s_start, s_stop, s_step, s_off;
  logic [15:0] s_dwell;
  bit          s_loop;
  logic [1:0]  s_sty;
  slot_t       m_slots[$];

  task automatic model_reset();
    m_state = M_IDLE; m_ftw = '0; m_phase = '0; m_off = '0; m_sty = '0; m_done = 0;
    s_start = '0; s_stop = '0; s_step = '0; s_off = '0; s_dwell = '0; s_loop = 0; s_sty = '0;
    m_slots.delete();
  endtask

  // One pass as a per-cycle list of (ftw, sweep_done) slots.
  task automatic build_pass(input bit first_pass);
    longint v, stp, stop_v;
    bit     is_stop;
    m_slots.delete();
    v      = longint'(s_start);
    stop_v = longint'(s_stop);
    stp    = (s_step == 0) ? 1 : longint'(s_step);
    while (1) begin
      is_stop = (v == stop_v);
      if (!(is_stop && !s_loop && s_start != s_stop))
        for (int r = 0; r <= int'(s_dwell); r++)
          m_slots.push_back('{f: 28'(v),
                              done: is_stop && r == 0 && (s_start != s_stop || !first_pass)});
      if (is_stop) break;
      if (stop_v > v) v = (v + stp > stop_v) ? stop_v : v + stp;
      else            v = (v - stp < stop_v) ? stop_v : v - stp;
    end
  endtask

  task automatic model_clock();
    slot_t s;
    bit    xf;
    xf     = cfg_valid && (m_state != M_SWEEP);
    m_done = 0;
    if (abort) begin
      model_reset();
    end else if (xf) begin
      s_start = cfg_start_ftw; s_stop = cfg_stop_ftw; s_step = cfg_step; s_dwell = cfg_dwell;
      s_loop = cfg_loop; s_sty = cfg_wave_style; s_off = cfg_phase_offset;
      m_state = M_ARMED; m_phase = '0;
    end else if (start && (m_state == M_ARMED || m_state == M_HOLD)) begin
      build_pass(1);
      s = m_slots.pop_front();
      m_ftw = s.f; m_phase = '0; m_off = s_off; m_sty = s_sty; m_state = M_SWEEP;
    end else if (m_state == M_SWEEP) begin
      m_phase = m_phase + m_ftw;
      if (m_slots.size() == 0 && !s_loop) begin
        m_state = M_HOLD; m_ftw = s_stop; m_done = 1;
      end else begin
        if (m_slots.size() == 0) begin
          build_pass(0);
`ifdef DDS_SWEEP_PHASE_SYNC_EN
          m_phase = '0;
`endif
        end
        s = m_slots.pop_front();
        m_ftw = s.f; m_done = s.done;
      end
    end else if (m_state == M_HOLD) begin
      m_phase = m_phase + m_ftw;
    end
  endtask

  task automatic randomize_cfg();
    logic [27:0] a, b;
    longint      diff;
    if ($urandom_range(0, 3) != 0) begin
      cfg_start_ftw = 28'($urandom_range(0, 60));
      cfg_stop_ftw  = 28'($urandom_range(0, 60));
      cfg_step      = 28'($urandom_range(0, 15));
    end else begin
      a = 28'($urandom); b = 28'($urandom);
      diff = (a > b) ? longint'(a) - longint'(b) : longint'(b) - longint'(a);
      cfg_start_ftw = a; cfg_stop_ftw = b;
      cfg_step      = 28'((diff >> $urandom_range(1, 4)) + 1);
    end
    if ($urandom_range(0, 7) == 0) cfg_stop_ftw = cfg_start_ftw;
    cfg_dwell        = 16'($urandom_range(0, 3));
    cfg_loop         = 1'($urandom_range(0, 1));
    cfg_wave_style   = 2'($urandom_range(0, 3));
    cfg_phase_offset = 28'($urandom);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [27:0] st, sp, stp; logic [15:0] dw; bit lp; logic [1:0] sty; logic [27:0] off;
  } cfg_t;

  typedef struct {
    bit v, s, a; int cid;
    logic [27:0] e_ftw, e_ph; bit e_busy, e_done, e_ready; logic [1:0] e_sty; logic [27:0] e_off;
  } vec_t;

  cfg_t cfgs[3];
  vec_t vecs[$];

  task automatic add(input bit v, input bit s, input bit a, input int cid,
                     input logic [27:0] f, input logic [27:0] ph, input bit b, input bit d,
                     input bit r, input logic [1:0] sty, input logic [27:0] off);
    vecs.push_back('{v: v, s: s, a: a, cid: cid, e_ftw: f, e_ph: ph, e_busy: b, e_done: d,
                     e_ready: r, e_sty: sty, e_off: off});
  endtask

  initial begin
    logic [27:0] ph23, ph24, ph25;
    localparam logic [27:0] OFF0 = 28'h0000ABC;
    localparam logic [27:0] OFF1 = 28'h1234567;
    localparam logic [27:0] OFF2 = 28'h0FFFFFF;

    cfgs[0] = '{st: 100, sp: 130, stp: 10, dw: 2, lp: 0, sty: 2'b10, off: OFF0};
    cfgs[1] = '{st: 50,  sp: 5,   stp: 20, dw: 0, lp: 0, sty: 2'b01, off: OFF1};
    cfgs[2] = '{st: 0,   sp: 2,   stp: 1,  dw: 0, lp: 1, sty: 2'b11, off: OFF2};
`ifdef DDS_SWEEP_PHASE_SYNC_EN
    ph23 = 0; ph24 = 0; ph25 = 1;
`else
    ph23 = 3; ph24 = 3; ph25 = 4;
`endif
    //  v  s  a  cfg  ftw  phase busy done ready style off
    add(1, 0, 0, 0,   0,   0,    0, 0, 1, 2'b00, 0);     // load up-sweep, ARMED
    add(0, 1, 0, 0, 100,   0,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 100, 100,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 100, 200,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 110, 300,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 110, 410,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 110, 520,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 120, 630,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 120, 750,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 120, 870,    1, 0, 0, 2'b10, OFF0);
    add(0, 0, 0, 0, 130, 990,    0, 1, 1, 2'b10, OFF0);  // HOLD
    add(0, 0, 0, 0, 130, 1120,   0, 0, 1, 2'b10, OFF0);
    add(0, 0, 0, 0, 130, 1250,   0, 0, 1, 2'b10, OFF0);
    add(1, 0, 0, 1, 130,   0,    0, 0, 1, 2'b10, OFF0);  // transfer from HOLD
    add(0, 1, 0, 1,  50,   0,    1, 0, 0, 2'b01, OFF1);
    add(1, 0, 0, 2,  30,  50,    1, 0, 0, 2'b01, OFF1);  // offers refused in SWEEP
    add(1, 0, 0, 2,  10,  80,    1, 0, 0, 2'b01, OFF1);
    add(1, 0, 0, 2,   5,  90,    0, 1, 1, 2'b01, OFF1);
    add(0, 0, 0, 2,   5,  95,    0, 0, 1, 2'b01, OFF1);
    add(1, 0, 0, 2,   5,   0,    0, 0, 1, 2'b01, OFF1);
    add(0, 1, 0, 2,   0,   0,    1, 0, 0, 2'b11, OFF2);  // loop sweep
    add(0, 0, 0, 2,   1,   0,    1, 0, 0, 2'b11, OFF2);
    add(0, 0, 0, 2,   2,   1,    1, 1, 0, 2'b11, OFF2);
    add(0, 0, 0, 2,   0, ph23,   1, 0, 0, 2'b11, OFF2);
    add(0, 0, 0, 2,   1, ph24,   1, 0, 0, 2'b11, OFF2);
    add(0, 0, 0, 2,   2, ph25,   1, 1, 0, 2'b11, OFF2);
    add(1, 1, 1, 0,   0,   0,    0, 0, 1, 2'b00, 0);     // abort beats start and transfer
    add(0, 1, 0, 0,   0,   0,    0, 0, 1, 2'b00, 0);     // start in IDLE ignored

    rst_n = 1'b0; cfg_valid = 0; start = 0; abort = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post_reset", 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_t c;
      c = cfgs[vecs[i].cid];
      set_cfg(c.st, c.sp, c.stp, c.dw, c.lp, c.sty, c.off);
      drive_cycle(vecs[i].v, vecs[i].s, vecs[i].a);
      check_outs($sformatf("vec%0d", i), vecs[i].e_ftw, vecs[i].e_ph, vecs[i].e_sty,
                 vecs[i].e_off, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ready);
    end

    // step of 0 behaves as 1
    set_cfg(3, 6, 0, 0, 0, 2'b00, 28'h5);
    drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 0);
    check("step0 ftw start", 64'(ftw), 64'd3);
    for (int k = 4; k <= 6; k++) begin
      drive_cycle(0, 0, 0);
      check($sformatf("step0 ftw %0d", k), 64'(ftw), 64'(k));
    end
    check("step0 hold {busy,done}", 64'({busy, sweep_done}), 64'(2'b01));

    // start == stop, non-loop: one dwell period, then done and HOLD
    set_cfg(7, 7, 5, 1, 0, 2'b01, 28'h9);
    drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 0);
    check("eq cyc0 {ftw,busy,done}", 64'({ftw, busy, sweep_done}), 64'({28'd7, 2'b10}));
    drive_cycle(0, 0, 0);
    check("eq cyc1 {ftw,busy,done}", 64'({ftw, busy, sweep_done}), 64'({28'd7, 2'b10}));
    drive_cycle(0, 0, 0);
    check("eq cyc2 {ftw,busy,done}", 64'({ftw, busy, sweep_done}), 64'({28'd7, 2'b01}));
    drive_cycle(0, 0, 0);
    check("eq cyc3 {ftw,busy,done}", 64'({ftw, busy, sweep_done}), 64'({28'd7, 2'b00}));

    // asynchronous reset mid-sweep, observed before any clock edge
    set_cfg(cfgs[0].st, cfgs[0].sp, cfgs[0].stp, cfgs[0].dw, 0, cfgs[0].sty, cfgs[0].off);
    drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 0);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 0);
    check("pre_async busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      abort     = ($urandom_range(0, 63) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      start     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) randomize_cfg();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_outs($sformatf("rand%0d", n), m_ftw, m_phase, m_sty, m_off,
                 m_state == M_SWEEP, m_done, m_state != M_SWEEP);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
